// File: rtl/ptp_ts_arb.sv
// ptp_ts_arb: round-robin read-side drain of the RX/TX PTP time-stamp queues onto one tagged valid/ready stream
module ptp_ts_arb #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       src_mask,
  input  logic [7:0]       rx_q_rd_stat,
  output logic             rx_q_rd_en,
  input  logic [127:0]     rx_q_rd_data,
  input  logic [7:0]       tx_q_rd_stat,
  output logic             tx_q_rd_en,
  input  logic [127:0]     tx_q_rd_data,
  output logic             ts_valid,
  input  logic             ts_ready,
  output logic [127:0]     ts_data,
  output logic             ts_src,
  output logic [CNT_W-1:0] rx_ts_cnt,
  output logic [CNT_W-1:0] tx_ts_cnt,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, READ, WAIT, PRESENT} state_t;
  state_t state, state_nx;
  logic sel, last_grant, gnt, gnt_sel, rx_el, tx_el, hs;
  logic [1:0] wcnt;
  logic unused_stat;
  assign unused_stat = ^{rx_q_rd_stat[7:4], tx_q_rd_stat[7:4]};
  assign rx_el = enable & src_mask[0] & (rx_q_rd_stat[3:0] != 4'd0);
  assign tx_el = enable & src_mask[1] & (tx_q_rd_stat[3:0] != 4'd0);
  assign hs    = (state == PRESENT) & ts_valid & ts_ready;
  assign busy  = state != IDLE;
  always_comb begin
    gnt      = 1'b0;
    gnt_sel  = 1'b0;
    state_nx = state;
    case (state)
      IDLE: begin
        gnt      = rx_el | tx_el;
        gnt_sel  = (rx_el & tx_el) ? ~last_grant : tx_el;
        state_nx = gnt ? READ : IDLE;
      end
      READ:    state_nx = WAIT;
      WAIT:    state_nx = (wcnt == 2'd0) ? PRESENT : WAIT;
      PRESENT: state_nx = hs ? IDLE : PRESENT;
      default: state_nx = IDLE;
    endcase
  end
  // last_grant resets to TX so the first tie goes to RX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      wcnt       <= 2'd0;
      rx_q_rd_en <= 1'b0;
      tx_q_rd_en <= 1'b0;
      ts_valid   <= 1'b0;
      ts_data    <= '0;
      ts_src     <= 1'b0;
      rx_ts_cnt  <= '0;
      tx_ts_cnt  <= '0;
    end else begin
      state      <= state_nx;
      rx_q_rd_en <= gnt & ~gnt_sel;
      tx_q_rd_en <= gnt & gnt_sel;
      if (gnt) sel <= gnt_sel;
      if (state == READ) wcnt <= 2'(RD_LAT - 1);
      else if (state == WAIT) wcnt <= wcnt - 2'd1;
      if (state == WAIT && wcnt == 2'd0) begin
        ts_data  <= sel ? tx_q_rd_data : rx_q_rd_data;
        ts_src   <= sel;
        ts_valid <= 1'b1;
      end
      if (hs) begin
        ts_valid   <= 1'b0;
        last_grant <= sel;
        if (sel) tx_ts_cnt <= tx_ts_cnt + CNT_W'(1);
        else rx_ts_cnt <= rx_ts_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ptp_ts_arb.sv
// tb_ptp_ts_arb: scoreboard bench; two instances (RD_LAT=1/CNT_W=16 and RD_LAT=3/CNT_W=4) fed by latency-accurate queue models
module tb_ptp_ts_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rst_n [2];
  logic         enable [2];
  logic [1:0]   mask [2];
  logic         ready [2];
  logic [7:0]   stat [2][2];
  logic [127:0] rdata [2][2];
  logic         rden [2][2];
  logic         tv [2];
  logic [127:0] td [2];
  logic         tsrc [2];
  logic         busy [2];
  logic [15:0]  rc0, tc0;
  logic [3:0]   rc1, tc1;
  int wr_cnt [2][2];
  int rd_ptr [2][2];
  int dly [2][2];
  int eidx [2][2];
  int pulses [2][2];
  int last_rd [2];
  bit has_last [2];
  bit tv_prev [2];
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  typedef struct packed {logic d; logic s; logic [127:0] v;} exp_t;
  exp_t eq[$];

  ptp_ts_arb #(.RD_LAT(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .enable(enable[0]), .src_mask(mask[0]),
    .rx_q_rd_stat(stat[0][0]), .rx_q_rd_en(rden[0][0]), .rx_q_rd_data(rdata[0][0]),
    .tx_q_rd_stat(stat[0][1]), .tx_q_rd_en(rden[0][1]), .tx_q_rd_data(rdata[0][1]),
    .ts_valid(tv[0]), .ts_ready(ready[0]), .ts_data(td[0]), .ts_src(tsrc[0]),
    .rx_ts_cnt(rc0), .tx_ts_cnt(tc0), .busy(busy[0]));
  ptp_ts_arb #(.RD_LAT(3), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .enable(enable[1]), .src_mask(mask[1]),
    .rx_q_rd_stat(stat[1][0]), .rx_q_rd_en(rden[1][0]), .rx_q_rd_data(rdata[1][0]),
    .tx_q_rd_stat(stat[1][1]), .tx_q_rd_en(rden[1][1]), .tx_q_rd_data(rdata[1][1]),
    .ts_valid(tv[1]), .ts_ready(ready[1]), .ts_data(td[1]), .ts_src(tsrc[1]),
    .rx_ts_cnt(rc1), .tx_ts_cnt(tc1), .busy(busy[1]));

  function automatic int lat(int d);
    return d == 0 ? 1 : 3;
  endfunction

  function automatic logic [127:0] ent(int s, int i);
    if (s == 0 && i == 0) return 128'h0000_000000000005_1234ABCD_1A2B_0007;
    return {16'h0, 48'(i + 1), 32'h5000_0000 + 32'(s * 256 + i), 4'(s + 2), 12'(i * 7), 16'(100 + i)};
  endfunction

  // queue models: read data appears RD_LAT-1 edges after the rd_en edge, garbage before
  always_comb
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 2; s++)
        stat[d][s] = {4'hA, 4'(wr_cnt[d][s] - rd_ptr[d][s])};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 2; s++)
        if (rden[d][s]) begin
          rd_ptr[d][s] <= rd_ptr[d][s] + 1;
          if (lat(d) == 1) rdata[d][s] <= ent(s, rd_ptr[d][s]);
          else begin
            dly[d][s]   <= lat(d) - 1;
            rdata[d][s] <= {4{32'hDEAD_BEEF}};
          end
        end else if (dly[d][s] != 0) begin
          dly[d][s] <= dly[d][s] - 1;
          if (dly[d][s] == 1) rdata[d][s] <= ent(s, rd_ptr[d][s] - 1);
        end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rden[d][0] || rden[d][1]) begin
        checks++;
        if (rden[d][0] && rden[d][1]) begin fails++; $display("FAIL rd_simul dut%0d: both rd_en high", d); end
        checks++;
        if (tv[d]) begin fails++; $display("FAIL rd_while_valid dut%0d: rd_en with ts_valid=1", d); end
        if (has_last[d]) begin
          checks++;
          if (cyc - last_rd[d] < lat(d) + 3) begin
            fails++; $display("FAIL rd_spacing dut%0d: got %0d cycles, need >= %0d", d, cyc - last_rd[d], lat(d) + 3);
          end
        end
        last_rd[d] = cyc;
        has_last[d] = 1'b1;
        for (int s = 0; s < 2; s++) if (rden[d][s]) pulses[d][s]++;
      end
      if (tv[d] && !tv_prev[d]) begin
        checks++;
        if (cyc - last_rd[d] != lat(d) + 1) begin
          fails++; $display("FAIL latency dut%0d: got %0d, expected %0d", d, cyc - last_rd[d], lat(d) + 1);
        end
      end
      tv_prev[d] = tv[d];
      if (tv[d] && ready[d]) begin
        checks++;
        if (eq.size() == 0) begin
          fails++; $display("FAIL unexpected dut%0d: src=%0d data=%h", d, tsrc[d], td[d]);
        end else begin
          exp_t e;
          e = eq.pop_front();
          if (e.d != d[0] || e.s != tsrc[d] || e.v != td[d]) begin
            fails++;
            $display("FAIL delivery dut%0d: got src=%0d data=%h, expected dut%0d src=%0d data=%h", d, tsrc[d], td[d], e.d, e.s, e.v);
          end
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(int d, int s);
    eq.push_back({d[0], s[0], ent(s, eidx[d][s])});
    eidx[d][s]++;
  endtask

  task automatic load(int d, int s, int n);
    wr_cnt[d][s] += n;
  endtask

  task automatic wait_empty(int max);
    int n = 0;
    while (eq.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", 128'(eq.size()), 128'd0);
    eq.delete();
  endtask

  task automatic wait_rden(int d, int s);
    int n = 0;
    while (!rden[d][s] && n < 40) begin
      tick(1);
      n++;
    end
    chk("rden_seen", 128'(rden[d][s]), 128'd1);
  endtask

  initial begin
    logic [127:0] snap_d;
    logic snap_s;
    int psum;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; enable[d] = 1'b0; mask[d] = 2'b00; ready[d] = 1'b0;
    end
    tick(3);
    chk("reset_out0", {rden[0][0], rden[0][1], tv[0], tsrc[0], busy[0], rc0, tc0}, 128'd0);
    chk("reset_data0", td[0], 128'd0);
    chk("reset_out1", {rden[1][0], rden[1][1], tv[1], tsrc[1], busy[1], rc1, tc1, td[1]}, 128'd0);
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; enable[d] = 1'b1; mask[d] = 2'b11; ready[d] = 1'b1;
    end
    tick(1);
    // single RX entry
    push(0, 0); load(0, 0, 1);
    wait_empty(50);
    chk("t1_rx_cnt", 128'(rc0), 128'd1);
    chk("t1_tx_cnt", 128'(tc0), 128'd0);
    chk("t1_rx_pulses", 128'(pulses[0][0]), 128'd1);
    chk("t1_tx_pulses", 128'(pulses[0][1]), 128'd0);
    // both queues at 3, fresh arbitration state
    rst_n[0] = 1'b0; tick(2); rst_n[0] = 1'b1; tick(1);
    for (int i = 0; i < 3; i++) begin push(0, 0); push(0, 1); end
    load(0, 0, 3); load(0, 1, 3);
    wait_empty(100);
    chk("t2_rx_cnt", 128'(rc0), 128'd3);
    chk("t2_tx_cnt", 128'(tc0), 128'd3);
    chk("t2_rx_pulses", 128'(pulses[0][0]), 128'd4);
    chk("t2_tx_pulses", 128'(pulses[0][1]), 128'd3);
    // backpressure
    ready[0] = 1'b0;
    push(0, 0); push(0, 1); load(0, 0, 1); load(0, 1, 1);
    for (int n = 0; n < 30 && !tv[0]; n++) tick(1);
    chk("t3_valid", 128'(tv[0]), 128'd1);
    snap_d = td[0]; snap_s = tsrc[0]; psum = pulses[0][0] + pulses[0][1];
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t3_hold", {tv[0], busy[0], tsrc[0], td[0]}, {1'b1, 1'b1, snap_s, snap_d});
    end
    chk("t3_no_rd", 128'(pulses[0][0] + pulses[0][1]), 128'(psum));
    ready[0] = 1'b1;
    wait_empty(50);
    chk("t3_rx_cnt", 128'(rc0), 128'd4);
    chk("t3_tx_cnt", 128'(tc0), 128'd4);
    // enable dropped in WAIT
    push(0, 0); load(0, 0, 2);
    wait_rden(0, 0);
    tick(1);
    enable[0] = 1'b0;
    wait_empty(50);
    psum = pulses[0][0];
    tick(20);
    chk("t4_no_rd", 128'(pulses[0][0]), 128'(psum));
    chk("t4_rx_cnt", 128'(rc0), 128'd5);
    chk("t4_stat", 128'(stat[0][0][3:0]), 128'd1);
    push(0, 0); enable[0] = 1'b1;
    wait_empty(50);
    chk("t4_resume_cnt", 128'(rc0), 128'd6);
    // mask=TX only, RD_LAT=3
    mask[1] = 2'b10;
    push(1, 1); push(1, 1); load(1, 0, 2); load(1, 1, 2);
    wait_empty(100);
    tick(10);
    chk("t5_rx_pulses", 128'(pulses[1][0]), 128'd0);
    chk("t5_tx_cnt", 128'(tc1), 128'd2);
    chk("t5_rx_cnt", 128'(rc1), 128'd0);
    chk("t5_rx_stat", 128'(stat[1][0][3:0]), 128'd2);
    // asynchronous reset during WAIT loses the popped entry
    mask[1] = 2'b01;
    wait_rden(1, 0);
    tick(1);
    rst_n[1] = 1'b0;
    #1;
    chk("t6_async_rst", {rden[1][0], rden[1][1], tv[1], tsrc[1], busy[1], rc1, tc1, td[1]}, 128'd0);
    eidx[1][0]++;
    load(1, 1, 1);
    mask[1] = 2'b11;
    push(1, 0); push(1, 1);
    tick(5);
    rst_n[1] = 1'b1;
    wait_empty(100);
    chk("t6_rx_cnt", 128'(rc1), 128'd1);
    chk("t6_tx_cnt", 128'(tc1), 128'd1);
    // counter wrap at CNT_W=4
    rst_n[1] = 1'b0; tick(2); rst_n[1] = 1'b1; mask[1] = 2'b01;
    for (int i = 0; i < 9; i++) push(1, 0);
    load(1, 0, 9);
    wait_empty(200);
    chk("t7_rx_cnt9", 128'(rc1), 128'd9);
    for (int i = 0; i < 8; i++) push(1, 0);
    load(1, 0, 8);
    wait_empty(200);
    chk("t7_rx_wrap", 128'(rc1), 128'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
